// File: rtl/sprite_bus_pkg.sv
// Shared definitions for the sprite register-write bus: register select
// codes, the writer state encoding and the buffered update record.
package sprite_bus_pkg;

    localparam logic [1:0] ADDR_X   = 2'b00;
    localparam logic [1:0] ADDR_Y   = 2'b01;
    localparam logic [1:0] ADDR_DIR = 2'b10;

    // Sprite index is carried wider than any practical NUM_SPRITES so the
    // record layout does not depend on the top-level parameters.
    localparam int SPRITE_IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_X   = 2'd1,
        ST_WR_Y   = 2'd2,
        ST_WR_DIR = 2'd3
    } writer_state_t;

    typedef struct packed {
        logic [SPRITE_IDX_W-1:0] sprite;
        logic [31:0]             x;
        logic [31:0]             y;
        logic [31:0]             dir;
    } update_rec_t;

endpackage

// File: rtl/sprite_req_fifo.sv
// Synchronous FIFO of sprite update records. DEPTH must be a power of two
// (>= 2) so the read/write pointers wrap naturally.
module sprite_req_fifo
    import sprite_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  update_rec_t push_data,
    input  logic        pop,
    output update_rec_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    update_rec_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Record storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sprite_reg_writer.sv
// Sprite register writer: buffers position updates and, only while vblank_i
// is high, drains each one as three write beats (X, Y, DIR) to the addressed
// sprite controller. Optional macro SPRITE_CLAMP_EN clamps X/Y to the visible
// area inset by HALF_SIZE on the way out.
module sprite_reg_writer
    import sprite_bus_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int HALF_SIZE   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [$clog2(NUM_SPRITES)-1:0] req_sprite_i,
    input  logic [31:0]                    req_x_i,
    input  logic [31:0]                    req_y_i,
    input  logic [31:0]                    req_dir_i,
    input  logic                           vblank_i,
    output logic [NUM_SPRITES-1:0]         MW_o,
    output logic [1:0]                     address_o,
    output logic [31:0]                    data_o,
    output logic                           busy_o
);

`ifdef SPRITE_CLAMP_EN
    localparam logic [31:0] X_MIN = 32'(HALF_SIZE);
    localparam logic [31:0] X_MAX = 32'(H_ACTIVE - HALF_SIZE - 1);
    localparam logic [31:0] Y_MIN = 32'(HALF_SIZE);
    localparam logic [31:0] Y_MAX = 32'(V_ACTIVE - HALF_SIZE - 1);
`endif

    writer_state_t          state;
    writer_state_t          state_nxt;
    update_rec_t            req_rec;
    update_rec_t            fifo_out;
    update_rec_t            work;
    update_rec_t            src;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [NUM_SPRITES-1:0] mw_nxt;
    logic [1:0]             addr_nxt;
    logic [31:0]            data_nxt;

    // One-hot strobe for a sprite index; out-of-range indices select nobody.
    function automatic logic [NUM_SPRITES-1:0] sprite_strobe(input logic [SPRITE_IDX_W-1:0] idx);
        logic [NUM_SPRITES-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (idx == SPRITE_IDX_W'(i)) s[i] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] clamp_x(input logic [31:0] v);
`ifdef SPRITE_CLAMP_EN
        if (v < X_MIN) return X_MIN;
        if (v > X_MAX) return X_MAX;
`endif
        return v;
    endfunction

    function automatic logic [31:0] clamp_y(input logic [31:0] v);
`ifdef SPRITE_CLAMP_EN
        if (v < Y_MIN) return Y_MIN;
        if (v > Y_MAX) return Y_MAX;
`endif
        return v;
    endfunction

    assign req_rec = '{sprite: SPRITE_IDX_W'(req_sprite_i),
                       x:      req_x_i,
                       y:      req_y_i,
                       dir:    req_dir_i};

    assign req_ready_o = ~fifo_full;
    assign push        = req_valid_i & ~fifo_full;
    // A new record may start only from IDLE or straight after the DIR beat.
    assign pop         = ((state == ST_IDLE) || (state == ST_WR_DIR)) & ~fifo_empty & vblank_i;
    assign busy_o      = ~fifo_empty | (state != ST_IDLE);

    sprite_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (req_rec),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: fixed X->Y->DIR walk, with back-to-back restart out of DIR.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pop) state_nxt = ST_WR_X;
            ST_WR_X:   state_nxt = ST_WR_Y;
            ST_WR_Y:   state_nxt = ST_WR_DIR;
            ST_WR_DIR: state_nxt = pop ? ST_WR_X : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next beat contents; the X beat uses the record being popped this edge.
    always_comb begin
        src      = (state_nxt == ST_WR_X) ? fifo_out : work;
        mw_nxt   = '0;
        addr_nxt = ADDR_X;
        data_nxt = '0;
        case (state_nxt)
            ST_WR_X: begin
                mw_nxt   = sprite_strobe(src.sprite);
                addr_nxt = ADDR_X;
                data_nxt = clamp_x(src.x);
            end
            ST_WR_Y: begin
                mw_nxt   = sprite_strobe(src.sprite);
                addr_nxt = ADDR_Y;
                data_nxt = clamp_y(src.y);
            end
            ST_WR_DIR: begin
                mw_nxt   = sprite_strobe(src.sprite);
                addr_nxt = ADDR_DIR;
                data_nxt = src.dir;
            end
            default: ;
        endcase
    end

    // Working copy of the record being written, captured at pop.
    always_ff @(posedge clk) begin
        if (pop) work <= fifo_out;
    end

    // Registered bus outputs so each beat is stable for a whole clock period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MW_o      <= '0;
            address_o <= ADDR_X;
            data_o    <= '0;
        end else begin
            MW_o      <= mw_nxt;
            address_o <= addr_nxt;
            data_o    <= data_nxt;
        end
    end

endmodule

// File: doc/sprite_reg_writer.md
Name: sprite_reg_writer

Overview:
Bus master that drives the sprite/score controllers' register-write port (MW, 2-bit address, 32-bit data) from a queue of position updates from game logic. Each update is buffered in a small FIFO, then drained only during vertical blanking as a 3-beat write sequence (X, Y, DIR) to one sprite, so sprite positions never change mid-frame. Sits between game-logic FSM and the array of sprite controllers in the graphic controller.

Parameters:
NUM_SPRITES, 4, number of sprite controllers addressed; one MW strobe each
FIFO_DEPTH, 4, update records buffered (power of 2, >=2)
H_ACTIVE, 640, visible width in pixels (clamp feature only)
V_ACTIVE, 480, visible height in pixels (clamp feature only)
HALF_SIZE, 16, sprite half-extent in pixels (clamp feature only)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  update request valid
req_ready_o  out  1  request accepted when valid & ready at rising edge
req_sprite_i  in  $clog2(NUM_SPRITES)  target sprite index
req_x_i  in  32  new sprite centre x
req_y_i  in  32  new sprite centre y
req_dir_i  in  32  new direction word
vblank_i  in  1  high during vertical blanking, synchronous to clk
MW_o  out  NUM_SPRITES  one-hot write strobe, bit i -> sprite controller i
address_o  out  2  register select: 00 x, 01 y, 10 dir
data_o  out  32  write data
busy_o  out  1  high when FIFO non-empty or sequence in progress

Behaviour:
- Reset (async assert, sync deassert): FIFO empty, state IDLE, MW_o=0, address_o=0, data_o=0, busy_o=0, req_ready_o=1 after deassert. Reset mid-sequence aborts the partial write; remaining beats never issue.
- req_ready_o = !fifo_full (combinational from FIFO count). Accept pushes {sprite,x,y,dir}. Valid while full: not accepted, request must hold; no drop, no overwrite.
- FSM states IDLE, WR_X, WR_Y, WR_DIR. All outputs registered.
- IDLE: if !empty & vblank_i at edge E -> pop record into working register, go WR_X. Else stay, MW_o=0.
- WR_X: MW_o=onehot(sprite), address_o=00, data_o=x; next WR_Y.
- WR_Y: same strobe, address_o=01, data_o=y; next WR_DIR.
- WR_DIR: same strobe, address_o=10, data_o=dir; next: if !empty & vblank_i pop and go WR_X (back-to-back, 3 cycles/record, no idle gap), else IDLE.
- Each beat held stable for one full clk period, so controllers sampling on falling edge see settled data.
- vblank_i dropping mid-sequence: current record completes all 3 beats; no new pop until vblank_i high again.
- Simultaneous push and pop in same edge: both take effect, count unchanged; legal when full (pop frees slot but ready was low, so no push that cycle).
- Latency: accept at edge T into empty FIFO with vblank_i high -> pop at T+1, X beat visible cycle after T+1, DIR beat 2 cycles later.
- Sprite index >= NUM_SPRITES: record popped and consumed, MW_o stays 0 for its 3 beats (address/data still driven).
- busy_o = !empty | (state != IDLE).

Optional Feature:
SPRITE_CLAMP_EN: defined -> x clamped to [HALF_SIZE, H_ACTIVE-HALF_SIZE-1], y to [HALF_SIZE, V_ACTIVE-HALF_SIZE-1] (unsigned compare) when driven on data_o; dir unchanged. Not defined -> x/y passed unmodified.

Decomposition:
- Package sprite_bus_pkg: ADDR_X=2'b00, ADDR_Y=2'b01, ADDR_DIR=2'b10, writer state enum, packed update-record struct {sprite,x,y,dir}.
- Sub-module sprite_req_fifo: synchronous FIFO of records, DEPTH param, push/pop/full/empty, async active-low reset.

Test Plan:
- Single update sprite 2, x=100,y=200,dir=1, vblank_i=1 -> MW_o=0100 for 3 consecutive cycles, addr 00/01/10, data 100/200/1, then MW_o=0, busy_o=0.
- vblank_i=0, push 4 records -> req_ready_o low after 4th, 5th held; no MW_o; raise vblank_i -> 12 back-to-back beats in FIFO order, 5th accepted after first pop.
- vblank_i falls during WR_Y of record 1 (2 queued) -> WR_DIR completes, then MW_o=0 until vblank_i returns.
- rst_n low during WR_Y -> MW_o=0 immediately (async), FIFO empty, no DIR beat after release.
- Push and pop same edge at count=2 -> count stays 2, order preserved.
- SPRITE_CLAMP_EN defined, x=5, y=700 -> data_o 16 then 463; undefined -> 5 then 700.
